// File: rtl/pipe_mem_arbiter_if.sv
// pipe_mem_arbiter_if
// Bundles every signal between the pipeline, the arbiter and the unified
// memory model into one interface.
//   master : the environment side. It drives the fetch/data requests and the
//            memory response, and observes the memory strobes, the returned
//            instruction/data, the done pulses and the stalls.
//   slave  : the arbiter side, with the opposite directions.
// Fetch   : if_req, if_adr -> if_inst, if_done, stall_if
// Data    : d_read, d_write, d_adr, d_wdata -> d_rdata, d_done, stall_mem
// Memory  : mem_adr, mem_wdata, mem_rd, mem_wr -> mem_rdata, mem_ack
interface pipe_mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
) ();
  logic          if_req;
  logic [AW-1:0] if_adr;
  logic          d_read;
  logic          d_write;
  logic [AW-1:0] d_adr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
  logic [AW-1:0] mem_adr;
  logic [DW-1:0] mem_wdata;
  logic          mem_rd;
  logic          mem_wr;
  logic [DW-1:0] if_inst;
  logic          if_done;
  logic [DW-1:0] d_rdata;
  logic          d_done;
  logic          stall_if;
  logic          stall_mem;

  modport master (
    output if_req, if_adr, d_read, d_write, d_adr, d_wdata, mem_rdata, mem_ack,
    input  mem_adr, mem_wdata, mem_rd, mem_wr, if_inst, if_done, d_rdata,
           d_done, stall_if, stall_mem
  );

  modport slave (
    input  if_req, if_adr, d_read, d_write, d_adr, d_wdata, mem_rdata, mem_ack,
    output mem_adr, mem_wdata, mem_rd, mem_wr, if_inst, if_done, d_rdata,
           d_done, stall_if, stall_mem
  );
endinterface

// File: rtl/pipe_mem_arbiter.sv
// pipe_mem_arbiter
// Shares one single-ported, variable-latency memory between the instruction
// fetch port and the MEM-stage data port. Each access goes through IDLE (the
// arbitration cycle), then FETCH or DATA until the memory acks. It returns the
// fetched instruction and the load data, and generates the stalls that freeze
// the front end and the whole pipeline while an access is outstanding.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset. It abandons any in-flight access.
//   bus  : pipe_mem_arbiter_if.slave, which carries the fetch, data and memory signals
// Optional feature: define ARB_STARVE_GUARD_EN to add a starvation guard. After
// STARVE_MAX consecutive arbitration losses, fetch is granted ahead of pending data.
// Without the macro, data always wins.
module pipe_mem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 3
) (
  input logic               clk,
  input logic               rst,
  pipe_mem_arbiter_if.slave bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] mem_adr_q, mem_adr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          mem_rd_q, mem_rd_d;
  logic          mem_wr_q, mem_wr_d;
  logic [DW-1:0] if_inst_q, if_inst_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;

  logic data_req;
  logic fetch_ack;
  logic data_ack;
  logic load_ack;
  logic grant_fetch;
  logic grant_data;
  logic starve_force;

  assign data_req  = bus.d_read | bus.d_write;
  // An ack is only meaningful while an access is outstanding. A stray ack in IDLE is ignored.
  assign fetch_ack = (state_q == ST_FETCH) & bus.mem_ack;
  assign data_ack  = (state_q == ST_DATA) & bus.mem_ack;
  // A store completes through DATA too. Only a load carries read data.
  assign load_ack  = data_ack & mem_rd_q;

`ifdef ARB_STARVE_GUARD_EN
  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  logic [SW-1:0] starve_q, starve_d;

  assign starve_force = (starve_q == STARVE_LIM);

  // Starve counter: counts IDLE cycles where a waiting fetch lost to data. It clears when fetch is granted.
  always_comb begin
    starve_d = starve_q;
    if (state_q == ST_IDLE) begin
      if (grant_fetch) begin
        starve_d = {SW{1'b0}};
      end else if (bus.if_req && data_req && (starve_q != STARVE_LIM)) begin
        starve_d = starve_q + SW'(1);
      end else begin
        starve_d = starve_q;
      end
    end else begin
      starve_d = starve_q;
    end
  end

  // Starve counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q <= {SW{1'b0}};
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign starve_force = 1'b0;
`endif

  // Data normally wins because it belongs to the older instruction.
  assign grant_fetch = (state_q == ST_IDLE) & bus.if_req & (~data_req | starve_force);
  assign grant_data  = (state_q == ST_IDLE) & data_req & ~grant_fetch;

  // FSM next state and memory request registers. Address and strobes hold until the ack.
  always_comb begin
    state_d     = state_q;
    mem_adr_d   = mem_adr_q;
    mem_wdata_d = mem_wdata_q;
    mem_rd_d    = mem_rd_q;
    mem_wr_d    = mem_wr_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_data) begin
          state_d     = ST_DATA;
          mem_adr_d   = bus.d_adr;
          mem_wdata_d = bus.d_wdata;
          mem_rd_d    = bus.d_read;
          mem_wr_d    = bus.d_write;
        end else if (grant_fetch) begin
          state_d   = ST_FETCH;
          mem_adr_d = bus.if_adr;
          mem_rd_d  = 1'b1;
          mem_wr_d  = 1'b0;
        end else begin
          state_d  = ST_IDLE;
          mem_rd_d = 1'b0;
          mem_wr_d = 1'b0;
        end
      end
      ST_FETCH, ST_DATA: begin
        if (bus.mem_ack) begin
          state_d  = ST_IDLE;
          mem_rd_d = 1'b0;
          mem_wr_d = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        mem_rd_d = 1'b0;
        mem_wr_d = 1'b0;
      end
    endcase
  end

  // Returned-value holds: capture memory data on the completing cycle, otherwise keep the last value.
  always_comb begin
    if (fetch_ack) begin
      if_inst_d = bus.mem_rdata;
    end else begin
      if_inst_d = if_inst_q;
    end
    if (load_ack) begin
      d_rdata_d = bus.mem_rdata;
    end else begin
      d_rdata_d = d_rdata_q;
    end
  end

  // State and datapath registers. Reset abandons any in-flight access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mem_adr_q   <= {AW{1'b0}};
      mem_wdata_q <= {DW{1'b0}};
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      if_inst_q   <= {DW{1'b0}};
      d_rdata_q   <= {DW{1'b0}};
    end else begin
      state_q     <= state_d;
      mem_adr_q   <= mem_adr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      if_inst_q   <= if_inst_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign bus.mem_adr   = mem_adr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_rd    = mem_rd_q;
  assign bus.mem_wr    = mem_wr_q;
  // The instruction and load data pass through combinationally on the completing cycle.
  assign bus.if_inst   = if_inst_d;
  assign bus.d_rdata   = d_rdata_d;
  assign bus.if_done   = fetch_ack;
  assign bus.d_done    = data_ack;
  assign bus.stall_if  = bus.if_req & ~fetch_ack;
  assign bus.stall_mem = data_req & ~data_ack;

endmodule
